// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the core's load/store data port.
//
// Takes one request at a time over a valid/ready request channel. After a
// configurable access latency it returns load data or a store acknowledgement
// over a valid/ready response channel. Storage is word organised with byte
// enables. Misaligned and out-of-range accesses are flagged on rsp_err and
// have no effect on storage.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   srst       synchronous active-high reset (storage is not cleared)
//   req_valid  request present          req_ready  responder can accept
//   req_we     1=store, 0=load          req_addr   byte address
//   req_wdata  store data               req_be     byte enables
//   rsp_valid  response present         rsp_ready  requester accepts response
//   rsp_rdata  load data (0 for stores/errors)
//   rsp_err    access error for this response
//
// Build option: define DMEM_BACK2BACK_EN to accept a new request in the same
// cycle as the response handshake, so the FSM skips IDLE between transactions.

module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam logic [63:0] MemBytes = 64'(DEPTH_WORDS) * 64'd4;
  localparam logic [3:0]  CntInit  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam bit          ZeroLat  = (LATENCY == 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

  logic        accept, rsp_hs, start, latch, commit, commit_live;
  logic        c_we, c_err;
  logic [31:0] c_addr, c_wdata, c_off;
  logic [3:0]  c_be;
  logic [IdxW-1:0] c_idx;

  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign accept    = req_valid && req_ready;
  assign rsp_hs    = rsp_valid && rsp_ready;

  always_comb begin
    req_ready = 1'b0;
    unique case (state_q)
      StIdle:  req_ready = 1'b1;
`ifdef DMEM_BACK2BACK_EN
      StResp:  req_ready = rsp_ready;
`else
      StResp:  req_ready = 1'b0;
`endif
      default: req_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start       = 1'b0;
    latch       = 1'b0;
    commit      = 1'b0;
    commit_live = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) start = 1'b1;
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_hs) begin
          state_d = StIdle;
`ifdef DMEM_BACK2BACK_EN
          // req_ready follows rsp_ready here, so accept implies the handshake.
          if (accept) start = 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
    if (start) begin
      latch = 1'b1;
      if (ZeroLat) begin
        // No wait state: commit straight from the request inputs.
        state_d     = StResp;
        commit      = 1'b1;
        commit_live = 1'b1;
      end else begin
        state_d = StWait;
        cnt_d   = CntInit;
      end
    end
  end

  // Transaction being committed: live inputs on a zero-latency accept,
  // otherwise the latched request.
  assign c_we    = commit_live ? req_we    : we_q;
  assign c_addr  = commit_live ? req_addr  : addr_q;
  assign c_wdata = commit_live ? req_wdata : wdata_q;
  assign c_be    = commit_live ? req_be    : be_q;
  // Addresses below BASE_ADDR wrap to large offsets and fail the range check.
  assign c_off   = c_addr - BASE_ADDR;
  assign c_err   = (c_addr[1:0] != 2'b00) || ({32'd0, c_off} >= MemBytes);
  assign c_idx   = c_off[IdxW+1:2];

  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (rsp_hs) begin
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
    end
    if (commit) begin
      rsp_err_d   = c_err;
      rsp_rdata_d = (!c_we && !c_err) ? mem_q[c_idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (latch) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!srst && commit && c_we && !c_err) begin
      for (int b = 0; b < 4; b++) begin
        if (c_be[b]) mem_q[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
      end
    end
  end

endmodule
